// File: rtl/program_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> 16-bit instruction-memory writes; holds the CPU until loaded.
// Optional trailing checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, FLUSH,
`ifdef LOADER_CHECKSUM_EN
    CSUM_HI, CSUM_LO,
`endif
    RUN, ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM_HI;
  logic [15:0] sum;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  state_t      state, state_next;
  logic [7:0]  hi_byte;
  logic [15:0] word_count;
  logic [15:0] rx_word;
  logic        accept;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign rx_word   = {hi_byte, in_data};
  assign last_word = (words_loaded + 16'd1 == word_count);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CSUM_HI, CSUM_LO:                 in_ready = 1'b1;
`endif
      default:                          in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      LEN_HI:  if (accept) state_next = LEN_LO;
      LEN_LO:
        if (accept) begin
          if (32'(rx_word) > 32'(MAX_WORDS)) state_next = ERROR;
          else if (rx_word == 16'd0)        state_next = AFTER_DATA;
          else                              state_next = DATA_HI;
        end
      DATA_HI: if (accept) state_next = DATA_LO;
      DATA_LO: if (accept) state_next = last_word ? FLUSH : DATA_HI;
      // One idle cycle so the CPU is released only after the final write has landed.
      FLUSH:   state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      CSUM_HI: if (accept) state_next = CSUM_LO;
      CSUM_LO: if (accept) state_next = (rx_word == sum) ? RUN : ERROR;
`endif
      RUN, ERROR: if (reload) state_next = LEN_HI;
      default: state_next = LEN_HI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      state        <= LEN_HI;
      hi_byte      <= 8'd0;
      word_count   <= 16'd0;
      words_loaded <= 16'd0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 16'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= 16'd0;
`endif
    end else begin
      state    <= state_next;
      imem_we  <= 1'b0;
      cpu_hold <= (state_next != RUN);
      done     <= (state_next == RUN);
      error    <= (state_next == ERROR);
      case (state)
        LEN_HI:  if (accept) hi_byte <= in_data;
        LEN_LO:  if (accept) word_count <= rx_word;
        DATA_HI: if (accept) hi_byte <= in_data;
        DATA_LO:
          if (accept) begin
            imem_we      <= 1'b1;
            imem_addr    <= BASE_ADDR + words_loaded;
            imem_wdata   <= rx_word;
            words_loaded <= words_loaded + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            sum          <= sum + rx_word;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
        CSUM_HI: if (accept) hi_byte <= in_data;
`endif
        RUN, ERROR:
          if (reload) begin
            words_loaded <= 16'd0;
            word_count   <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= 16'd0;
`endif
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader; the image model and write scoreboard live here.
module tb_program_loader;
  localparam logic [15:0] BASE = 16'h0010;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        pc_reset, in_valid, reload;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [15:0] imem_addr, imem_wdata, words_loaded;

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .pc_reset(pc_reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] addr; logic [15:0] data;} wr_t;

  int          checks = 0, failures = 0;
  logic [15:0] img[$];
  logic [7:0]  stream[$];
  wr_t         exp_q[$];
  wr_t         got;
  logic [20:0] exp_status;
  int          seen = 0, cyc = 0, last_we_cyc = -1, fall_cyc = -1;
  logic        prev_hold = 1'b1;

  function automatic logic [20:0] status();
    return {in_ready, imem_we, cpu_hold, done, error, words_loaded};
  endfunction

  // Write scoreboard: every imem_we pulse must match the next expected write.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_hold === 1'b1 && cpu_hold === 1'b0) fall_cyc = cyc;
    prev_hold = cpu_hold;
    if (imem_we === 1'b1) begin
      last_we_cyc = cyc;
      seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        got = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== got || words_loaded !== 16'(seen)) begin
          failures++;
          $display("FAIL write_%0d: got addr=%h data=%h count=%0d, required addr=%h data=%h count=%0d",
                   seen, imem_addr, imem_wdata, words_loaded, got.addr, got.data, seen);
        end
      end
    end
  end

  // Reference model: byte stream, expected writes and final status from the word list in img.
  task automatic build_image(input bit bad_csum);
    int          n = img.size();
    logic [15:0] len = 16'(n);
    logic [15:0] s = 16'd0;
    bit          ok = (n <= MAXW);
    stream.delete(); exp_q.delete();
    seen = 0; last_we_cyc = -1; fall_cyc = -1;
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        stream.push_back(img[i][15:8]);
        stream.push_back(img[i][7:0]);
        exp_q.push_back('{addr: BASE + 16'(i), data: img[i]});
        s = s + img[i];
      end
`ifdef LOADER_CHECKSUM_EN
      if (bad_csum) begin
        s  = s + 16'd1;
        ok = 1'b0;
      end
      stream.push_back(s[15:8]);
      stream.push_back(s[7:0]);
`endif
    end
    exp_status = {1'b0, 1'b0, !ok, ok, !ok, (n <= MAXW) ? 16'(n) : 16'd0};
  endtask

  task automatic random_image(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(16'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      int n = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL send_timeout: byte %h not accepted within 50 cycles, required acceptance", b);
  endtask

  task automatic send_stream(input bit gaps, input int count);
    for (int i = 0; i < count; i++) send_byte(stream[i], gaps);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    pc_reset = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    pc_reset = 1'b0;
    exp_q.delete(); seen = 0; last_we_cyc = -1; fall_cyc = -1;
  endtask

  task automatic load_and_check(input string name, input bit gaps, input bit bad_csum);
    bit ok;
    build_image(bad_csum);
    send_stream(gaps, stream.size());
    wait_end(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_settle: done/error still low after 40 cycles, required one of them high", name);
    end
    checks++;
    if (status() !== exp_status) begin
      failures++;
      $display("FAIL %s_status: got %h, required %h", name, status(), exp_status);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes: %0d expected writes missing, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0} || {imem_addr, imem_wdata} !== {BASE, 16'h0000}) begin
      failures++;
      $display("FAIL reset_values: got status=%h addr=%h data=%h, required status=%h addr=%h data=0000",
               status(), imem_addr, imem_wdata, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}, BASE);
    end
  endtask

  task automatic test_example();
    apply_reset();
    img = '{16'h1234, 16'h5678, 16'h9ABC};
    load_and_check("example", 1'b0, 1'b0);
    checks++;
`ifdef LOADER_CHECKSUM_EN
    if (!(fall_cyc > last_we_cyc && last_we_cyc >= 0)) begin
`else
    if (fall_cyc != last_we_cyc + 1 || last_we_cyc < 0) begin
`endif
      failures++;
      $display("FAIL example_hold_timing: hold fell at cycle %0d, last write at %0d, required one cycle after",
               fall_cyc, last_we_cyc);
    end
`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    load_and_check("bad_checksum", 1'b0, 1'b1);
`endif
  endtask

  task automatic test_length();
    apply_reset();
    random_image(MAXW + 1);
    build_image(1'b0);
    send_stream(1'b0, stream.size());
    checks++;
    if (status() !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0} || last_we_cyc != -1) begin
      failures++;
      $display("FAIL length_error: got status=%h last_write_cycle=%0d, required status=%h and no write",
               status(), last_we_cyc, {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0});
    end
    apply_reset();
    random_image(MAXW);
    load_and_check("max_words", 1'b0, 1'b0);
    apply_reset();
    img.delete();
    load_and_check("zero_words", 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      random_image($urandom_range(1, 8));
      load_and_check("gaps", 1'b1, 1'b0);
      repeat (5) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (status() !== exp_status) begin
        failures++;
        $display("FAIL run_ignores_bytes: got %h, required %h", status(), exp_status);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    random_image(3);
    build_image(1'b0);
    send_stream(1'b0, 6);
    #2 pc_reset = 1'b1;
    #1;
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0} || {imem_addr, imem_wdata} !== {BASE, 16'h0000}) begin
      failures++;
      $display("FAIL mid_reset: got status=%h addr=%h data=%h, required reset values",
               status(), imem_addr, imem_wdata);
    end
    apply_reset();
    random_image(3);
    load_and_check("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_reload();
    apply_reset();
    random_image(2);
    load_and_check("first_image", 1'b0, 1'b0);
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reload_restart: got %h, required %h", status(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
    end
    @(negedge clk);
    reload = 1'b0;
    random_image(4);
    build_image(1'b0);
    // reload held during the first bytes must be ignored while loading.
    for (int i = 0; i < stream.size(); i++) begin
      reload = (i < 4);
      send_byte(stream[i], 1'b0);
    end
    reload = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    begin
      bit ok;
      wait_end(ok);
      checks++;
      if (!ok || status() !== exp_status || exp_q.size() != 0) begin
        failures++;
        $display("FAIL second_image: got status=%h pending=%0d, required status=%h pending=0",
                 status(), exp_q.size(), exp_status);
      end
    end
  endtask

  initial begin
    pc_reset = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
    test_reset();
    test_example();
    test_length();
    test_gaps();
    test_mid_reset();
    test_reload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500 us, required completion");
    $fatal(1, "watchdog");
  end

endmodule
